mux_rr_arb: RTL and testbench

- Parametrised successor to the cascaded 2:1 bit-mux datapath.
- Selects one of CHANNELS input streams, each WIDTH bits wide, and drives a single registered output stream.
- Input and output streams use valid/ready handshakes.
- Two selection modes: fixed select, and fair round-robin arbitration.
- Intended as the shared-output selector ahead of the uo_out pins in the tile.

---
 rtl/mux_rr_arb.sv | 257 +++++++++++++++++++++++++
 tb/tb_mux_rr_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arb.sv
// mux_rr_arb -- shared-output stream selector with fixed-select and
// round-robin arbitration modes.
//
// CHANNELS input streams of WIDTH bits each compete for one registered
// output stream. All streams use valid/ready handshakes. The output stage is
// a single register slice. It can take a new word in the same cycle the
// held word is consumed, so it sustains one word per cycle.
//
// Optional build feature:
//   MUX_RR_ARB_STATS_EN  -- when defined, adds per-channel saturating 8-bit
//                           grant counters, the stat_sel input and the
//                           stat_cnt output. When undefined, none of this
//                           logic or these ports exist.
module mux_rr_arb #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel_in,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  input  logic                      out_ready
`ifdef MUX_RR_ARB_STATS_EN
  ,
  input  logic [SELW-1:0]           stat_sel,
  output logic [7:0]                stat_cnt
`endif
);

  // Mode encoding on the mode pin.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Highest channel index. The round-robin pointer wraps to 0 after this.
  localparam logic [SELW-1:0] LAST_CHAN = SELW'(CHANNELS - 1);

  // ---------------------------------------------------------------------
  // Internal signals
  // ---------------------------------------------------------------------
  logic                load_en_s;     // output register can take a word
  logic                accept_s;      // a word is transferred this cycle
  logic [CHANNELS-1:0] fixed_grant_s; // grant candidate in fixed mode
  logic [CHANNELS-1:0] rr_grant_s;    // grant candidate in round-robin mode
  logic                rr_found_s;    // round-robin search found a channel
  logic [SELW-1:0]     rr_idx_s;      // channel being inspected by the search
  logic [CHANNELS-1:0] grant_s;       // one-hot (or zero) grant
  logic                grant_any_s;   // some channel is granted
  logic [SELW-1:0]     grant_idx_s;   // binary index of the granted channel
  logic [WIDTH-1:0]    grant_data_s;  // data word of the granted channel
  logic [SELW-1:0]     rr_next_s;     // pointer value after a round-robin grant

  logic                out_valid_r;
  logic [WIDTH-1:0]    out_data_r;
  logic [SELW-1:0]     out_chan_r;
  logic [SELW-1:0]     rr_ptr_r;      // highest-priority channel for next search

  // ---------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------

  // Saturating increment for the 8-bit statistics counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == 8'hFF) begin
      result = 8'hFF;
    end else begin
      result = value + 8'h01;
    end
    return result;
  endfunction

  // Modulo-CHANNELS successor of a channel index.
  function automatic logic [SELW-1:0] next_chan(input logic [SELW-1:0] idx);
    logic [SELW-1:0] result;
    if (idx == LAST_CHAN) begin
      result = '0;
    end else begin
      result = idx + SELW'(1);
    end
    return result;
  endfunction

  // ---------------------------------------------------------------------
  // Handshake qualification
  // ---------------------------------------------------------------------

  // The output slice can load when it is empty or its word leaves this cycle.
  always_comb begin
    load_en_s = ~out_valid_r | out_ready;
  end

  // ---------------------------------------------------------------------
  // Grant generation
  // ---------------------------------------------------------------------

  // Fixed mode: only the selected channel may win. Out-of-range selects win nothing.
  always_comb begin
    fixed_grant_s = '0;
    if (int'(sel_in) < CHANNELS) begin
      fixed_grant_s[sel_in] = in_valid[sel_in];
    end else begin
      fixed_grant_s = '0;
    end
  end

  // Round-robin: first valid channel starting at rr_ptr and wrapping around.
  always_comb begin
    rr_grant_s = '0;
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      rr_idx_s = SELW'((int'(rr_ptr_r) + i) % CHANNELS);
      if (!rr_found_s && in_valid[rr_idx_s]) begin
        rr_grant_s[rr_idx_s] = 1'b1;
        rr_found_s           = 1'b1;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Pick the grant vector of the active mode.
  always_comb begin
    grant_s = '0;
    case (mode)
      MODE_FIXED: grant_s = fixed_grant_s;
      MODE_RR:    grant_s = rr_grant_s;
      default:    grant_s = '0;
    endcase
  end

  // Encode the one-hot grant into an index and mux out the granted data word.
  always_comb begin
    grant_any_s  = |grant_s;
    grant_idx_s  = '0;
    grant_data_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (grant_s[k]) begin
        grant_idx_s  = SELW'(k);
        grant_data_s = in_data[k*WIDTH +: WIDTH];
      end else begin
        grant_idx_s  = grant_idx_s;
        grant_data_s = grant_data_s;
      end
    end
  end

  // Next pointer value: the channel just after the winner, wrapping.
  always_comb begin
    rr_next_s = next_chan(grant_idx_s);
  end

  // A transfer happens when the slice can load and somebody is granted.
  always_comb begin
    accept_s = load_en_s & grant_any_s;
  end

  // Upstream ready: at most one bit, and only while the slice can load.
  always_comb begin
    in_ready = '0;
    if (load_en_s) begin
      in_ready = grant_s;
    end else begin
      in_ready = '0;
    end
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------

  // Output register slice: load on a grant, drain when nothing is granted, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_chan_r  <= '0;
    end else if (load_en_s) begin
      if (grant_any_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= grant_data_s;
        out_chan_r  <= grant_idx_s;
      end else begin
        // Data and channel keep their last values. Only valid drops.
        out_valid_r <= 1'b0;
        out_data_r  <= out_data_r;
        out_chan_r  <= out_chan_r;
      end
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_chan_r  <= out_chan_r;
    end
  end

  // Round-robin pointer: moves only on accepted round-robin grants, survives mode changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (accept_s && (mode == MODE_RR)) begin
      rr_ptr_r <= rr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Drive the output ports straight from the registers.
  always_comb begin
    out_valid = out_valid_r;
    out_data  = out_data_r;
    out_chan  = out_chan_r;
  end

  // ---------------------------------------------------------------------
  // Optional grant statistics
  // ---------------------------------------------------------------------
`ifdef MUX_RR_ARB_STATS_EN
  logic [7:0] stat_cnt_r [CHANNELS];

  // Per-channel saturating count of accepted grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        stat_cnt_r[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (accept_s && grant_s[k]) begin
          stat_cnt_r[k] <= sat_inc8(stat_cnt_r[k]);
        end else begin
          stat_cnt_r[k] <= stat_cnt_r[k];
        end
      end
    end
  end

  // Read port for the counters. Out-of-range selects read as zero.
  always_comb begin
    stat_cnt = 8'h00;
    if (int'(stat_sel) < CHANNELS) begin
      stat_cnt = stat_cnt_r[stat_sel];
    end else begin
      stat_cnt = 8'h00;
    end
  end
`else
  // Statistics disabled: no counters and no extra ports. sat_inc8 is unused here.
`endif

endmodule

// File: tb/tb_mux_rr_arb.sv
// tb_mux_rr_arb -- self-checking bench for mux_rr_arb (CHANNELS=4, WIDTH=4).
// A transaction-level reference model predicts grants and the output
// register. Accepted words go into a scoreboard queue. A separate monitor
// pops and compares them on each output handshake. Build with
// MUX_RR_ARB_STATS_EN defined to also cover the grant counters.
module tb_mux_rr_arb;

  localparam int W  = 4;
  localparam int CH = 4;
  localparam int SW = 2;

  typedef struct {
    int         chan;
    logic [W-1:0] data;
  } word_t;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic            mode      = 1'b0;
  logic [SW-1:0]   sel_in    = 2'd0;
  logic [CH-1:0]   in_valid  = 4'h0;
  logic [CH*W-1:0] in_data   = 16'h0000;
  logic [CH-1:0]   in_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_chan;
  logic            out_ready = 1'b0;
`ifdef MUX_RR_ARB_STATS_EN
  logic [SW-1:0]   stat_sel  = 2'd0;
  logic [7:0]      stat_cnt;
`endif

  // Reference model state (after the most recent clock edge).
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_chan;
  int           m_rr;
  int           m_cnt [CH];
  bit           acc   [CH];
  bit           refill;

  word_t        sb_q[$];
  int           seen_chan[$];
  int           seen_data[$];

  int n_err    = 0;
  int n_checks = 0;

  mux_rr_arb #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel_in    (sel_in),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
`ifdef MUX_RR_ARB_STATS_EN
    ,
    .stat_sel  (stat_sel),
    .stat_cnt  (stat_cnt)
`endif
  );

  initial begin
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 4'h0;
    m_chan  = 0;
    m_rr    = 0;
    for (int k = 0; k < CH; k++) begin
      m_cnt[k] = 0;
      acc[k]   = 1'b0;
    end
    sb_q.delete();
  endtask

  // Called just before a rising edge: check the DUT now, then advance the model across the edge.
  task automatic model_cycle();
    int            g;
    bit            load;
    logic [CH-1:0] exp_rdy;
    g = -1;
    if (mode == 1'b0) begin
      if (int'(sel_in) < CH && in_valid[sel_in]) g = int'(sel_in);
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (g < 0 && in_valid[(m_rr + i) % CH]) g = (m_rr + i) % CH;
      end
    end
    load    = !m_valid || out_ready;
    exp_rdy = 4'h0;
    if (load && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready",  in_ready,  exp_rdy);
    chk("out_valid", out_valid, m_valid);
    chk("out_data",  out_data,  m_data);
    chk("out_chan",  out_chan,  m_chan);
`ifdef MUX_RR_ARB_STATS_EN
    chk("stat_cnt", stat_cnt, (int'(stat_sel) < CH) ? m_cnt[stat_sel] : 0);
`endif
    for (int k = 0; k < CH; k++) acc[k] = 1'b0;
    if (load) begin
      if (g >= 0) begin
        word_t w;
        w.chan  = g;
        w.data  = in_data[g*W +: W];
        sb_q.push_back(w);
        m_valid = 1'b1;
        m_data  = w.data;
        m_chan  = g;
        acc[g]  = 1'b1;
        if (mode == 1'b1) m_rr = (g + 1) % CH;
        if (m_cnt[g] < 255) m_cnt[g]++;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  // New random traffic. A channel that is valid but not yet accepted keeps its word.
  task automatic randomize_inputs();
    for (int k = 0; k < CH; k++) begin
      if (!(in_valid[k] && !acc[k])) begin
        in_valid[k]       = ($urandom_range(0, 9) < 6);
        in_data[k*W +: W] = W'($urandom);
      end
    end
    out_ready = ($urandom_range(0, 9) < 7);
    if ($urandom_range(0, 19) == 0) mode = ~mode;
    if ($urandom_range(0, 7) == 0) sel_in = SW'($urandom);
`ifdef MUX_RR_ARB_STATS_EN
    stat_sel = SW'($urandom);
`endif
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (refill) randomize_inputs();
  endtask

  // Monitor: each output handshake must deliver the oldest predicted word.
  always @(negedge clk) begin
    word_t w;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_underflow: actual=word chan %0d data %0h required=no word at t=%0t",
                 out_chan, out_data, $time);
      end else begin
        w = sb_q.pop_front();
        chk("sb_data", out_data, w.data);
        chk("sb_chan", out_chan, w.chan);
        seen_chan.push_back(int'(out_chan));
        seen_data.push_back(int'(out_data));
      end
    end
  end

  initial begin
    int rr_c [5];
    int rr_d [5];
    rr_c = '{0, 1, 2, 3, 0};
    rr_d = '{1, 2, 3, 4, 1};
    model_reset();
    refill = 1'b0;

    // Reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", out_valid, 32'd0);
    chk("reset_out_data",  out_data,  32'd0);
    chk("reset_out_chan",  out_chan,  32'd0);

    // Fixed select.
    mode = 1'b0; sel_in = 2'd2; in_valid = 4'hF; out_ready = 1'b1;
    in_data = {4'h4, 4'hA, 4'h2, 4'h1};
    #1 chk("fixed_in_ready", in_ready, 32'h4);
    step();
    chk("fixed_data", out_data, 32'hA);
    chk("fixed_chan", out_chan, 32'd2);
    step();
    in_valid[2] = 1'b0;
    step();
    chk("fixed_nogrant_valid", out_valid, 32'd0);
    chk("fixed_nogrant_data",  out_data,  32'hA);
    step();

    // Round robin across all four channels.
    mode = 1'b1; in_valid = 4'hF; in_data = {4'h4, 4'h3, 4'h2, 4'h1};
    seen_chan.delete(); seen_data.delete();
    repeat (6) step();
    chk("rr_count", seen_chan.size(), 32'd5);
    if (seen_chan.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("rr_chan_%0d", i), seen_chan[i], rr_c[i]);
        chk($sformatf("rr_data_%0d", i), seen_data[i], rr_d[i]);
      end
    end

    // Backpressure: ch1 word (0x2) is held while out_ready is low.
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("bp_hold_data",  out_data,  32'h2);
      chk("bp_hold_chan",  out_chan,  32'd1);
      chk("bp_hold_ready", in_ready,  32'h0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_resume_data", out_data, 32'h3);
    chk("bp_resume_chan", out_chan, 32'd2);

    // Sparse request with the pointer at 3, then a wrap from ch3 to 0.
    in_valid = 4'b0010;
    step();
    chk("sparse_chan", out_chan, 32'd1);
    chk("sparse_data", out_data, 32'h2);
    in_valid = 4'b1000;
    step();
    chk("wrap_chan", out_chan, 32'd3);
    chk("wrap_data", out_data, 32'h4);
    in_valid = 4'b1111;
    step();
    chk("wrap_next_chan", out_chan, 32'd0);

    // Asynchronous reset while a word is held.
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 32'd0);
    chk("async_rst_data",  out_data,  32'd0);
    chk("async_rst_chan",  out_chan,  32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("post_rst_valid", out_valid, 32'd1);
    chk("post_rst_chan",  out_chan,  32'd0);
    chk("post_rst_data",  out_data,  32'h1);

`ifdef MUX_RR_ARB_STATS_EN
    // Counter saturation and clear.
    rst = 1'b1;
    #1 model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    mode = 1'b0; sel_in = 2'd0; in_valid = 4'b0001; out_ready = 1'b1; stat_sel = 2'd0;
    repeat (300) step();
    #1 chk("stat_sat", stat_cnt, 32'd255);
    stat_sel = 2'd1;
    #1 chk("stat_other", stat_cnt, 32'd0);
    stat_sel = 2'd0;
    rst = 1'b1;
    #1 chk("stat_rst", stat_cnt, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
`endif

    // Randomized traffic against the model.
    refill = 1'b1;
    randomize_inputs();
    repeat (3000) step();
    refill = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
